mdu_unit: RTL and testbench

Multi-cycle multiply/divide unit for the 16-bit single-cycle MIPS datapath. It sits directly downstream of the ALU operand-select muxes and consumes the same selected operand pair the ALU does. It computes MULT/MULTU/DIV/DIVU into HI/LO registers over N+1 cycles, one bit per cycle. The control unit stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_step.sv | 39 +++
 rtl/mdu_unit.sv | 185 ++++++++++++++++++
 tb/tb_mdu_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// plus a ceil-log2 helper used to size the iteration counter.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  localparam int MDU_WIDTH_DEFAULT = 16;

  // Number of bits needed to hold values 0..value-1 (at least 1).
  function automatic int mdu_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multi-cycle datapath: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
//   multiply: acc = {partial_hi, multiplier_remaining}, opnd = multiplicand
//   divide:   acc = {partial_remainder, dividend/quotient}, opnd = divisor
module mdu_step
  import mdu_pkg::*;
#(
  parameter int N = MDU_WIDTH_DEFAULT
) (
  input  logic [2*N-1:0] acc_i,
  input  logic [N-1:0]   opnd_i,
  input  logic           is_div_i,
  output logic [2*N-1:0] acc_o
);

  logic [N:0] mul_sum;
  logic [N:0] div_shift;
  logic [N:0] div_diff;

  // Select between the add-and-shift-right and trial-subtract iterations.
  always_comb begin
    // The carry out of the add lands in bit 2N-1 after the right shift.
    mul_sum   = {1'b0, acc_i[2*N-1:N]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder is always below the divisor, so N+1 bits cover the shift;
    // the top bit of the difference is therefore a clean borrow flag.
    div_shift = {acc_i[2*N-1:N], acc_i[N-1]};
    div_diff  = div_shift - {1'b0, opnd_i};
    if (is_div_i) begin
      if (div_diff[N]) begin
        acc_o = {div_shift[N-1:0], acc_i[N-2:0], 1'b0};
      end else begin
        acc_o = {div_diff[N-1:0], acc_i[N-2:0], 1'b1};
      end
    end else begin
      acc_o = {mul_sum, acc_i[N-1:1]};
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit. Works on operand magnitudes one bit
// per cycle, then applies result signs and updates HI/LO in a final FIX cycle.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int N = MDU_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int CW = mdu_clog2(N);

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [N-1:0]   a_q, a_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;
  logic           neg_rem_q, neg_rem_d;
  logic           zero_q, zero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;

  logic [2*N-1:0] step_acc;
  logic           req_div;
  logic           req_signed;
  logic           sign_a;
  logic           sign_b;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] prod_signed;
  logic [N-1:0]   quo_signed;
  logic [N-1:0]   rem_signed;

  mdu_step #(.N(N)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc)
  );

  // Decode the incoming request and take operand magnitudes for signed ops.
  always_comb begin
    req_div    = (mdu_op_e'(op) == MDU_DIVU) || (mdu_op_e'(op) == MDU_DIV);
    req_signed = (mdu_op_e'(op) == MDU_MULT) || (mdu_op_e'(op) == MDU_DIV);
    sign_a     = req_signed & a[N-1];
    sign_b     = req_signed & b[N-1];
    // The most negative value maps onto itself, which reads correctly as
    // an unsigned magnitude.
    mag_a      = sign_a ? (~a + 1'b1) : a;
    mag_b      = sign_b ? (~b + 1'b1) : b;
  end

  // Sign fix-up of the finished magnitude result.
  always_comb begin
    prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_signed  = neg_q ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
    rem_signed  = neg_rem_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
  end

  // Next-state logic: IDLE latches the request, RUN iterates N times,
  // FIX publishes HI/LO and pulses done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          a_d       = a;
          is_div_d  = req_div;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          zero_d    = req_div && (b == '0);
          if (req_div) begin
            acc_d  = {{N{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{N{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MDU_RUN;
        end
      end
      MDU_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = MDU_FIX;
        end
      end
      MDU_FIX: begin
        if (is_div_q) begin
          if (zero_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = quo_signed;
            hi_d = rem_signed;
          end
          dbz_d = zero_q;
        end else begin
          {hi_d, lo_d} = prod_signed;
          dbz_d        = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: hand-computed results, latency, handshake
// and asynchronous-reset abort.
module tb_mdu_unit;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  mdu_unit #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Present a request now (caller is at a falling edge); returns one
  // falling edge after the accepting clock edge, with inputs scrambled.
  task automatic issue_now(input logic [1:0] o, input logic [N-1:0] xa, input logic [N-1:0] xb);
    start = 1'b1;
    op    = o;
    a     = xa;
    b     = xb;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = N'($urandom);
    b     = N'($urandom);
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] xa, input logic [N-1:0] xb);
    @(negedge clk);
    issue_now(o, xa, xb);
  endtask

  // Count falling edges until done, tracking busy cycles and checking that
  // HI/LO stay frozen and busy/done never overlap.
  task automatic wait_done(output int cyc, output int busy_cyc);
    logic [N-1:0] hi0;
    logic [N-1:0] lo0;
    int changes;
    int overlap;
    hi0 = hi;
    lo0 = lo;
    changes = 0;
    overlap = 0;
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      if (hi !== hi0 || lo !== lo0) changes++;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) overlap++;
    chk("hilo_frozen_while_busy", 32'(changes), 32'd0);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("busy_done_overlap", 32'(overlap), 32'd0);
  endtask

  task automatic expect_result(input string tag, input logic [N-1:0] ehi,
                               input logic [N-1:0] elo, input logic edbz);
    chk({tag, "_hi"}, {16'd0, hi}, {16'd0, ehi});
    chk({tag, "_lo"}, {16'd0, lo}, {16'd0, elo});
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    $display("op %s: hi=%h lo=%h dbz=%0d", tag, hi, lo, div_by_zero);
  endtask

  initial begin
    int cyc;
    int bcyc;
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;

    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("reset_hilo", {hi, lo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULTU FFFF*FFFF with latency and busy-length checks
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(cyc, bcyc);
    chk("multu_latency", 32'(cyc), 32'd17);
    chk("multu_busy_cycles", 32'(bcyc), 32'd17);
    expect_result("multu", 16'hFFFE, 16'h0001, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // MULT -3 * 5
    issue(2'b01, 16'hFFFD, 16'h0005);
    wait_done(cyc, bcyc);
    expect_result("mult_neg", 16'hFFFF, 16'hFFF1, 1'b0);

    // DIV -7 / 2
    issue(2'b11, 16'hFFF9, 16'h0002);
    wait_done(cyc, bcyc);
    expect_result("div_neg", 16'hFFFF, 16'hFFFD, 1'b0);

    // DIV overflow case
    issue(2'b11, 16'h8000, 16'hFFFF);
    wait_done(cyc, bcyc);
    expect_result("div_ovf", 16'h0000, 16'h8000, 1'b0);

    // DIVU by zero, still full latency
    issue(2'b10, 16'h0064, 16'h0000);
    wait_done(cyc, bcyc);
    chk("dbz_latency", 32'(cyc), 32'd17);
    expect_result("divu_zero", 16'h0064, 16'hFFFF, 1'b1);
    @(negedge clk);
    chk("dbz_held", {31'd0, div_by_zero}, 32'd1);

    // DIVU 100/7 clears the flag
    issue(2'b10, 16'h0064, 16'h0007);
    wait_done(cyc, bcyc);
    expect_result("divu", 16'h0002, 16'h000E, 1'b0);

    // start pulsed mid-RUN must be ignored
    issue(2'b00, 16'h0003, 16'h0007);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = 16'h1234;
    b     = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcyc);
    chk("ignored_start_latency", 32'(cyc), 32'd12);
    expect_result("ignored_start", 16'h0000, 16'h0015, 1'b0);

    // Back-to-back: MULT 0x7FFF*0x8000, then DIV 100/-7 held in done cycle
    issue(2'b01, 16'h7FFF, 16'h8000);
    wait_done(cyc, bcyc);
    expect_result("mult_b2b", 16'hC000, 16'h8000, 1'b0);
    issue_now(2'b11, 16'h0064, 16'hFFF9);
    chk("b2b_done_drop", {31'd0, done}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(cyc, bcyc);
    chk("b2b_latency", 32'(cyc), 32'd17);
    expect_result("div_b2b", 16'h0002, 16'hFFF2, 1'b0);

    // Asynchronous reset at RUN iteration 8
    issue(2'b00, 16'h1234, 16'h5678);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hilo", {hi, lo}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    issue(2'b00, 16'h0100, 16'h0100);
    wait_done(cyc, bcyc);
    chk("post_reset_latency", 32'(cyc), 32'd17);
    expect_result("post_reset", 16'h0001, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
